// File: rtl/serial_sequence_sender.sv
// rtl/serial_sequence_sender.sv - start pattern + MSB-first payload sender, one bit per clkEN strobe
// Optional trailing even-parity bit when SD_TX_PARITY_EN is defined.
module serial_sequence_sender #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1101,
  parameter int                     PAYLOAD_LEN = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clkEN,
  input  logic                               start,
  input  logic [PAYLOAD_LEN-1:0]             data_in,
  output logic                               SerOut,
  output logic                               SerOutValid,
  output logic                               busy,
  output logic                               done,
  // sized to hold PAYLOAD_LEN itself, so a full 16-bit payload reads as 16
  output logic [$clog2(PAYLOAD_LEN+1)-1:0]   cnt_out
);

`ifdef SD_TX_PARITY_EN
  localparam int PAR_LEN = 1;
`else
  localparam int PAR_LEN = 0;
`endif

  localparam int FRAME_LEN = PATTERN_LEN + PAYLOAD_LEN + PAR_LEN;
  localparam int BW        = $clog2(FRAME_LEN + 1);
  localparam int CW        = $clog2(PAYLOAD_LEN + 1);

  localparam logic [BW-1:0] FRAME_BITS    = BW'(FRAME_LEN);
  localparam logic [BW-1:0] FIRST_PAYLOAD = BW'(PAYLOAD_LEN + PAR_LEN);
  localparam logic [BW-1:0] LAST_PAYLOAD  = BW'(PAR_LEN + 1);
  localparam logic [BW-1:0] ONE_LEFT      = BW'(1);
  localparam logic [CW-1:0] CNT_MAX       = CW'(PAYLOAD_LEN);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t               state;
  logic [FRAME_LEN-1:0] shreg;
  logic [BW-1:0]        bits_left;
  logic [BW-1:0]        bits_dec;

  assign bits_dec = bits_left - ONE_LEFT;

  // shreg is zeroed outside SEND, so its MSB doubles as the idle-low line
  assign SerOut = shreg[FRAME_LEN-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bits_left   <= '0;
      cnt_out     <= '0;
      SerOutValid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
`ifdef SD_TX_PARITY_EN
            shreg     <= {PATTERN, data_in, ^data_in};
`else
            shreg     <= {PATTERN, data_in};
`endif
            bits_left   <= FRAME_BITS;
            cnt_out     <= '0;
            SerOutValid <= 1'b0;
            busy        <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          if (clkEN) begin
            if (SerOutValid && (cnt_out != CNT_MAX))
              cnt_out <= cnt_out + CW'(1);
            if (bits_left == ONE_LEFT) begin
              shreg       <= '0;
              SerOutValid <= 1'b0;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              shreg       <= {shreg[FRAME_LEN-2:0], 1'b0};
              bits_left   <= bits_dec;
              SerOutValid <= (bits_dec <= FIRST_PAYLOAD) && (bits_dec >= LAST_PAYLOAD);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          shreg       <= '0;
          SerOutValid <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
